// File: rtl/voice_ram_reader.sv
// Read-side controller for the voice sample ring buffer.
// Optional build macro: VOICE_RD_SILENCE_EN (emit SILENCE on underrun, keep playing).
module voice_ram_reader #(
    parameter int                ASIZE   = 13,
    parameter int                DSIZE   = 8,
    parameter int                PREFILL = 256,
    parameter logic [DSIZE-1:0]  SILENCE = DSIZE'(8'h80)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [ASIZE:0]   i_wr_ptr,
    output logic [ASIZE-1:0] o_rd_addr,
    input  logic [DSIZE-1:0] i_rd_data,
    output logic [ASIZE:0]   o_rd_ptr,
    output logic [DSIZE-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ASIZE:0]   o_level,
    output logic             o_underrun,
    output logic [15:0]      o_urun_cnt
);

`ifdef VOICE_RD_SILENCE_EN
    localparam bit SIL_EN = 1'b1;
`else
    localparam bit SIL_EN = 1'b0;
`endif

    localparam logic [ASIZE:0] PREFILL_L = (ASIZE+1)'(PREFILL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ASIZE:0]   rd_ptr;
    logic             take;
    logic             empty;
    logic             fetch;
    logic             urun;
    logic             drop;
    logic             sil;
    logic [DSIZE-1:0] urun_data;

    assign o_level   = i_wr_ptr - rd_ptr;
    assign empty     = (o_level == '0);
    assign take      = !o_valid || i_ready;
    assign o_rd_ptr  = rd_ptr;
    assign o_rd_addr = rd_ptr[ASIZE-1:0];

    // Silence keeps the stream alive only while playback is still enabled.
    assign sil       = SIL_EN && i_en;
    assign urun_data = sil ? SILENCE : o_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_en && o_level >= PREFILL_L) state_d = PLAY;
                end
                PLAY: begin
                    if (take && empty) state_d = sil ? PLAY : IDLE;
                    else if (!i_en)    state_d = DRAIN;
                end
                DRAIN: begin
                    if (take) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch = 1'b0;
        urun  = 1'b0;
        drop  = 1'b0;
        if (!i_flush) begin
            unique case (state_q)
                IDLE:  drop = take;
                PLAY: begin
                    if (take) begin
                        if (empty)     urun  = 1'b1;
                        else if (i_en) fetch = 1'b1;
                        else           drop  = 1'b1;
                    end
                end
                DRAIN: drop = take;
                default: drop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr     <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_underrun <= 1'b0;
            o_urun_cnt <= '0;
        end else begin
            o_underrun <= 1'b0;
            if (i_flush) begin
                rd_ptr  <= i_wr_ptr;
                o_valid <= 1'b0;
            end else if (fetch) begin
                o_data  <= i_rd_data;
                o_valid <= 1'b1;
                rd_ptr  <= rd_ptr + 1'b1;
            end else if (urun) begin
                o_underrun <= 1'b1;
                if (o_urun_cnt != 16'hFFFF) o_urun_cnt <= o_urun_cnt + 16'd1;
                o_data  <= urun_data;
                o_valid <= sil;
            end else if (drop) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
